// File: rtl/upload_arbiter.sv
// Packet-level round-robin arbiter for the command_processor upload channel.
// A granted handler owns the channel for a whole packet; a watchdog reclaims stalled grants.
module upload_arbiter #(
    parameter int NUM_SOURCES    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SOURCES-1:0]   src_upload_req,
    input  logic [NUM_SOURCES-1:0]   src_upload_valid,
    input  logic [8*NUM_SOURCES-1:0] src_upload_data,
    input  logic [8*NUM_SOURCES-1:0] src_upload_source,
    output logic [NUM_SOURCES-1:0]   src_upload_ready,
    output logic                     upload_req,
    output logic                     upload_valid,
    output logic [7:0]               upload_data,
    output logic [7:0]               upload_source,
    input  logic                     upload_ready,
    output logic [NUM_SOURCES-1:0]   grant_onehot,
    output logic                     arb_timeout
);

    localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SOURCES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [CNT_W-1:0] stall_cnt;
    logic             xfer;
    logic             stall_hit;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_SOURCES);
            if (!found && src_upload_req[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    // Once granted, the source's byte stream passes straight through with no added latency.
    always_comb begin
        upload_req       = 1'b0;
        upload_valid     = 1'b0;
        upload_data      = '0;
        upload_source    = '0;
        src_upload_ready = '0;
        if (state == GRANT) begin
            upload_req                  = src_upload_req[grant_idx];
            upload_valid                = src_upload_valid[grant_idx];
            upload_data                 = src_upload_data[{grant_idx, 3'b000} +: 8];
            upload_source               = src_upload_source[{grant_idx, 3'b000} +: 8];
            src_upload_ready[grant_idx] = upload_ready & src_upload_req[grant_idx];
        end
    end

    assign xfer      = upload_req & upload_valid & upload_ready;
    assign stall_hit = (TIMEOUT_CYCLES != 0) && (stall_cnt >= CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant_idx    <= '0;
            last_grant   <= IDX_LAST;
            stall_cnt    <= '0;
            grant_onehot <= '0;
            arb_timeout  <= 1'b0;
        end else begin
            arb_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state        <= GRANT;
                        grant_idx    <= next_idx;
                        last_grant   <= next_idx;
                        grant_onehot <= NUM_SOURCES'(1) << next_idx;
                        stall_cnt    <= '0;
                    end
                end
                GRANT: begin
                    // A timeout still pulses when it coincides with the source releasing req.
                    if (!src_upload_req[grant_idx]) begin
                        state        <= GAP;
                        grant_onehot <= '0;
                        stall_cnt    <= '0;
                        arb_timeout  <= stall_hit;
                    end else if (xfer) begin
                        stall_cnt <= '0;
                    end else if (stall_hit) begin
                        state        <= GAP;
                        grant_onehot <= '0;
                        stall_cnt    <= '0;
                        arb_timeout  <= 1'b1;
                    end else if (stall_cnt != CNT_MAX) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    grant_onehot <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upload_arbiter.sv
// Self-checking bench for upload_arbiter: behavioural sources feed packets and a
// scoreboard holds the bytes expected on the shared channel in grant order.
module tb_upload_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   src_upload_req;
    logic [N-1:0]   src_upload_valid;
    logic [8*N-1:0] src_upload_data;
    logic [8*N-1:0] src_upload_source;
    logic [N-1:0]   src_upload_ready;
    logic           upload_req;
    logic           upload_valid;
    logic [7:0]     upload_data;
    logic [7:0]     upload_source;
    logic           upload_ready;
    logic [N-1:0]   grant_onehot;
    logic           arb_timeout;

    int errors = 0;
    int checks = 0;

    int         rem[N];
    int         sent[N];
    logic [7:0] base[N];
    logic [7:0] tag[N];
    logic       hold[N];
    logic       race[N];
    logic [15:0]  sb[$];
    logic [N-1:0] grant_log[$];
    logic [N-1:0] prev_grant;

    upload_arbiter #(
        .NUM_SOURCES   (N),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .src_upload_req   (src_upload_req),
        .src_upload_valid (src_upload_valid),
        .src_upload_data  (src_upload_data),
        .src_upload_source(src_upload_source),
        .src_upload_ready (src_upload_ready),
        .upload_req       (upload_req),
        .upload_valid     (upload_valid),
        .upload_data      (upload_data),
        .upload_source    (upload_source),
        .upload_ready     (upload_ready),
        .grant_onehot     (grant_onehot),
        .arb_timeout      (arb_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            sent[i] = 0;
            base[i] = 8'h00;
            tag[i]  = 8'h00;
            hold[i] = 1'b0;
            race[i] = 1'b0;
        end
        sb.delete();
        grant_log.delete();
        prev_grant = '0;
    endtask

    task automatic load_packet(input int src, input int len, input logic [7:0] first, input logic [7:0] t);
        rem[src]  = len;
        sent[src] = 0;
        base[src] = first;
        tag[src]  = t;
    endtask

    task automatic push_expected(input int src, input int count);
        for (int k = 0; k < count; k++) begin
            sb.push_back({tag[src], base[src] + 8'(k)});
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            src_upload_req[i]             = (rem[i] > 0) || hold[i];
            src_upload_valid[i]           = (rem[i] > 0) || race[i];
            src_upload_data[8*i +: 8]     = base[i] + 8'(sent[i]);
            src_upload_source[8*i +: 8]   = tag[i];
        end
    endtask

    // Called once per cycle after inputs settle and well before the next rising edge.
    task automatic observe();
        logic [15:0] exp_byte;
        checkOutput("ready_leak", {28'h0, src_upload_ready & ~grant_onehot}, 32'h0);
        if (grant_onehot != '0 && prev_grant == '0) begin
            grant_log.push_back(grant_onehot);
        end
        prev_grant = grant_onehot;
        if (upload_req && upload_valid && upload_ready) begin
            checkOutput("xfer_ready", {28'h0, src_upload_ready}, {28'h0, grant_onehot});
            checkOutput("xfer_expected", 32'(sb.size() > 0), 32'h1);
            if (sb.size() > 0) begin
                exp_byte = sb.pop_front();
                checkOutput("xfer_byte", {16'h0, upload_source, upload_data}, {16'h0, exp_byte});
            end
            for (int i = 0; i < N; i++) begin
                if (grant_onehot[i] && rem[i] > 0) begin
                    rem[i]--;
                    sent[i]++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rdy);
        @(negedge clk);
        upload_ready = rdy;
        drive_inputs();
        #1;
        observe();
    endtask

    function automatic logic any_pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rem[i] > 0) p = 1'b1;
        end
        return p;
    endfunction

    // Runs until every loaded packet has gone through, then lets the FSM pass GAP back to IDLE.
    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while ((sb.size() != 0 || any_pending()) && n < max_cycles) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput({name, "_drained"}, 32'(sb.size()), 32'h0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_model();
        upload_ready      = 1'b1;
        src_upload_req    = '1;
        src_upload_valid  = '1;
        src_upload_data   = '1;
        src_upload_source = '1;
        #12;
        checkOutput("rst_upload_req", {31'h0, upload_req}, 32'h0);
        checkOutput("rst_upload_valid", {31'h0, upload_valid}, 32'h0);
        checkOutput("rst_upload_data", {24'h0, upload_data}, 32'h0);
        checkOutput("rst_upload_source", {24'h0, upload_source}, 32'h0);
        checkOutput("rst_src_ready", {28'h0, src_upload_ready}, 32'h0);
        checkOutput("rst_grant", {28'h0, grant_onehot}, 32'h0);
        checkOutput("rst_timeout", {31'h0, arb_timeout}, 32'h0);
        doReset();

        // Single source 2, four bytes with the channel always ready
        load_packet(2, 4, 8'hA1, 8'h06);
        push_expected(2, 4);
        applyStimulus(1'b1);
        checkOutput("t1_req_idle", {31'h0, upload_req}, 32'h0);
        applyStimulus(1'b1);
        checkOutput("t1_req_granted", {31'h0, upload_req}, 32'h1);
        checkOutput("t1_grant", {28'h0, grant_onehot}, 32'h4);
        checkOutput("t1_ready", {28'h0, src_upload_ready}, 32'h4);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1);
        checkOutput("t1_bytes", 32'(sent[2]), 32'd4);
        applyStimulus(1'b1);
        checkOutput("t1_release_req", {31'h0, upload_req}, 32'h0);
        applyStimulus(1'b1);
        checkOutput("t1_gap_grant", {28'h0, grant_onehot}, 32'h0);
        applyStimulus(1'b1);

        // All four sources request together from reset
        doReset();
        for (int i = 0; i < N; i++) begin
            load_packet(i, 2, 8'((i + 1) * 16), 8'(i + 1));
            push_expected(i, 2);
        end
        drain("t2", 60);
        checkOutput("t2_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < N; i++) begin
            checkOutput("t2_grant_order",
                        {28'h0, (grant_log.size() > i) ? grant_log[i] : 4'h0},
                        32'(1 << i));
        end

        // Backpressure on source 1 with ready pattern 1,0,0,1
        load_packet(1, 4, 8'hB0, 8'h02);
        push_expected(1, 4);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("t3_hold_data_a", {24'h0, upload_data}, 32'hB1);
        checkOutput("t3_no_ready_a", {28'h0, src_upload_ready}, 32'h0);
        applyStimulus(1'b0);
        checkOutput("t3_hold_data_b", {24'h0, upload_data}, 32'hB1);
        checkOutput("t3_no_ready_b", {28'h0, src_upload_ready}, 32'h0);
        applyStimulus(1'b1);
        checkOutput("t3_bytes", 32'(sent[1]), 32'd2);
        drain("t3", 20);

        // Source 3 stalls mid-packet while source 0 waits
        hold[3] = 1'b1;
        tag[3]  = 8'h04;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("t4_grant3", {28'h0, grant_onehot}, 32'h8);
        load_packet(0, 1, 8'hC0, 8'h01);
        push_expected(0, 1);
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(1'b1);
            checkOutput("t4_no_early_timeout", {31'h0, arb_timeout}, 32'h0);
        end
        checkOutput("t4_still_grant3", {28'h0, grant_onehot}, 32'h8);
        applyStimulus(1'b1);
        checkOutput("t4_pulse", {31'h0, arb_timeout}, 32'h1);
        checkOutput("t4_gap_req", {31'h0, upload_req}, 32'h0);
        applyStimulus(1'b1);
        checkOutput("t4_pulse_width", {31'h0, arb_timeout}, 32'h0);
        applyStimulus(1'b1);
        checkOutput("t4_grant0", {28'h0, grant_onehot}, 32'h1);
        checkOutput("t4_byte_sent", 32'(sent[0]), 32'd1);
        hold[3] = 1'b0;
        drain("t4", 10);

        // Source 1 drops req in the same cycle it offers 0x55
        load_packet(1, 1, 8'h54, 8'h02);
        push_expected(1, 1);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        race[1] = 1'b1;
        applyStimulus(1'b1);
        checkOutput("t5_no_ready", {28'h0, src_upload_ready}, 32'h0);
        checkOutput("t5_req_low", {31'h0, upload_req}, 32'h0);
        race[1] = 1'b0;
        applyStimulus(1'b1);
        checkOutput("t5_gap_grant", {28'h0, grant_onehot}, 32'h0);
        checkOutput("t5_bytes", 32'(sent[1]), 32'd1);
        applyStimulus(1'b1);

        // Reset lands while byte 3 of 6 from source 2 is on the channel
        load_packet(2, 6, 8'hD0, 8'h03);
        push_expected(2, 2);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        @(negedge clk);
        upload_ready = 1'b1;
        drive_inputs();
        #2;
        checkOutput("t6_pre_data", {24'h0, upload_data}, 32'hD2);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_req", {31'h0, upload_req}, 32'h0);
        checkOutput("t6_rst_valid", {31'h0, upload_valid}, 32'h0);
        checkOutput("t6_rst_data", {24'h0, upload_data}, 32'h0);
        checkOutput("t6_rst_source", {24'h0, upload_source}, 32'h0);
        checkOutput("t6_rst_ready", {28'h0, src_upload_ready}, 32'h0);
        checkOutput("t6_rst_grant", {28'h0, grant_onehot}, 32'h0);
        clear_model();
        applyStimulus(1'b1);
        load_packet(1, 2, 8'hF0, 8'h02);
        load_packet(0, 2, 8'hE0, 8'h01);
        push_expected(0, 2);
        push_expected(1, 2);
        @(negedge clk);
        rst_n = 1'b1;
        drain("t6", 40);
        checkOutput("t6_first_grant", {28'h0, (grant_log.size() > 0) ? grant_log[0] : 4'h0}, 32'h1);
        checkOutput("t6_second_grant", {28'h0, (grant_log.size() > 1) ? grant_log[1] : 4'h0}, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
